// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the I-cache request port and fills the IF/ID slot.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module pc_fetch_ctrl #(
   parameter int unsigned         ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              id_stall,
   output logic              ic_req,
   output logic [ADDR_W-1:0] ic_addr,
   input  logic              ic_ack,
   input  logic [31:0]       ic_rdata,
   output logic              if_valid,
   output logic [ADDR_W-1:0] if_pc,
   output logic [31:0]       if_inst
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       perf_stall_cyc,
   output logic [31:0]       perf_flush_cnt
`endif
);

   typedef enum logic [1:0] {StBoot, StFetch, StHold, StKill} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] tgt_q, tgt_d;
   logic              if_valid_q, if_valid_d;
   logic [ADDR_W-1:0] if_pc_q, if_pc_d;
   logic [31:0]       if_inst_q, if_inst_d;
   logic [ADDR_W-1:0] redir_tgt;
   logic [ADDR_W-1:0] pc_inc;
   logic              unused_redir_lsb;

   assign redir_tgt        = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign unused_redir_lsb = ^redirect_pc[1:0];
   assign pc_inc           = pc_q + ADDR_W'(4);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      tgt_d      = tgt_q;
      if_valid_d = if_valid_q;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;
      ic_req     = 1'b0;

      // Decode takes the slot in every cycle it is not stalled.
      if (!id_stall) if_valid_d = 1'b0;

      unique case (state_q)
         StBoot: begin
            state_d = StFetch;
         end
         StFetch: begin
            ic_req = 1'b1;
            if (redirect_valid) begin
               if_valid_d = 1'b0;
               if (ic_ack) begin
                  pc_d = redir_tgt;
               end else begin
                  tgt_d   = redir_tgt;
                  state_d = StKill;
               end
            end else if (ic_ack) begin
               if (if_valid_q && id_stall) begin
                  // Slot cannot accept: drop the word and refetch the same pc later.
                  state_d = StHold;
               end else begin
                  if_valid_d = 1'b1;
                  if_pc_d    = pc_q;
                  if_inst_d  = ic_rdata;
                  pc_d       = pc_inc;
               end
            end
         end
         StHold: begin
            if (redirect_valid) begin
               if_valid_d = 1'b0;
               pc_d       = redir_tgt;
               state_d    = StFetch;
            end else if (!id_stall) begin
               state_d = StFetch;
            end
         end
         StKill: begin
            ic_req = 1'b1;
            if (redirect_valid) if_valid_d = 1'b0;
            if (ic_ack) begin
               pc_d    = redirect_valid ? redir_tgt : tgt_q;
               state_d = StFetch;
            end else if (redirect_valid) begin
               tgt_d = redir_tgt;
            end
         end
         default: begin
            state_d = StBoot;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StBoot;
         pc_q       <= RESET_PC;
         tgt_q      <= RESET_PC;
         if_valid_q <= 1'b0;
         if_pc_q    <= '0;
         if_inst_q  <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         tgt_q      <= tgt_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_inst_q  <= if_inst_d;
      end
   end

   // The outstanding address lives in pc_q until it retires, keeping ic_addr stable.
   assign ic_addr  = pc_q;
   assign if_valid = if_valid_q;
   assign if_pc    = if_pc_q;
   assign if_inst  = if_inst_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cyc_q, stall_cyc_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cyc_d = stall_cyc_q;
      flush_cnt_d = flush_cnt_q;
      if (ic_req && !ic_ack && (stall_cyc_q != 32'hFFFF_FFFF)) begin
         stall_cyc_d = stall_cyc_q + 32'd1;
      end
      if (redirect_valid && (flush_cnt_q != 32'hFFFF_FFFF)) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cyc_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cyc_q <= stall_cyc_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign perf_stall_cyc = stall_cyc_q;
   assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus random traffic, with a program-order
// stream scoreboard checked by an independent monitor.
module tb_pc_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_stall = 1'b0;
   logic        ic_req;
   logic [31:0] ic_addr;
   logic        ic_ack = 1'b0;
   logic [31:0] ic_rdata = '0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_stall_cyc;
   logic [31:0] perf_flush_cnt;
   logic [31:0] m_stall = '0;
   logic [31:0] m_flush = '0;
`endif

   int errors = 0;
   int checks = 0;

   // Expected program-order PCs still to be consumed by decode.
   logic [31:0] exp_q[$];
   logic [31:0] tail_pc;

   always #5 clk = ~clk;

   pc_fetch_ctrl #(
      .ADDR_W   (32),
      .RESET_PC (RST_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_stall       (id_stall),
      .ic_req         (ic_req),
      .ic_addr        (ic_addr),
      .ic_ack         (ic_ack),
      .ic_rdata       (ic_rdata),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_inst        (if_inst)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_stall_cyc (perf_stall_cyc),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
   endfunction

   function automatic void top_up();
      while (exp_q.size() < 16) begin
         exp_q.push_back(tail_pc);
         tail_pc = tail_pc + 32'd4;
      end
   endfunction

   function automatic void restart(input logic [31:0] p);
      exp_q.delete();
      tail_pc = p;
      top_up();
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the cache only acks while a request is presented.
   task automatic cyc(input logic ack, input logic stall, input logic redir,
                      input logic [31:0] tgt);
      @(posedge clk);
      #1;
      rst            = 1'b1;
      ic_ack         = ack & ic_req;
      ic_rdata       = ic_ack ? mem(ic_addr) : 32'hDEAD_BEEF;
      id_stall       = stall;
      redirect_valid = redir;
      redirect_pc    = tgt;
      if (redir) restart({tgt[31:2], 2'b00});
   endtask

   // Holds reset for n cycles, then runs the boot cycle with an optional stale ack.
   task automatic do_reset(input int n, input logic boot_ack);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         rst            = 1'b0;
         ic_ack         = 1'b0;
         id_stall       = 1'b0;
         redirect_valid = 1'b0;
      end
      restart(RST_PC);
      @(posedge clk);
      #1;
      rst            = 1'b1;
      ic_ack         = boot_ack;
      ic_rdata       = 32'h1234_5678;
      id_stall       = 1'b0;
      redirect_valid = 1'b0;
      chk1("rst_req", ic_req, 1'b0);
      chk("rst_addr", ic_addr, RST_PC);
      chk1("rst_valid", if_valid, 1'b0);
      chk("rst_pc", if_pc, 32'h0);
      chk("rst_inst", if_inst, 32'h0);
   endtask

   // Monitor: protocol properties and the consumed-instruction stream.
   logic        p_rst = 1'b0, p_req = 1'b0, p_ack = 1'b0, p_valid = 1'b0;
   logic        p_stall = 1'b0, p_redir = 1'b0;
   logic [31:0] p_addr = '0, p_pc = '0, p_inst = '0;

   always @(negedge clk) begin
      logic [31:0] e;
      if (p_rst) begin
         if (p_req && !p_ack) begin
            chk1("req_held", ic_req, 1'b1);
            chk("addr_held", ic_addr, p_addr);
         end
         if (p_redir) begin
            chk1("redir_flush", if_valid, 1'b0);
         end else if (p_valid && p_stall) begin
            chk1("stall_valid", if_valid, 1'b1);
            chk("stall_pc", if_pc, p_pc);
            chk("stall_inst", if_inst, p_inst);
         end
      end
      if (rst && !redirect_valid && if_valid && !id_stall) begin
         if (exp_q.size() == 0) begin
            chk("stream_empty", if_pc, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("stream_pc", if_pc, e);
            chk("stream_inst", if_inst, mem(e));
            top_up();
         end
      end
`ifdef FETCH_PERF_CNT_EN
      if (!rst) begin
         m_stall <= '0;
         m_flush <= '0;
      end else begin
         if (ic_req && !ic_ack) m_stall <= m_stall + 32'd1;
         if (redirect_valid) m_flush <= m_flush + 32'd1;
      end
`endif
      p_rst   <= rst;
      p_req   <= ic_req;
      p_ack   <= ic_ack;
      p_valid <= if_valid;
      p_stall <= id_stall;
      p_redir <= redirect_valid;
      p_addr  <= ic_addr;
      p_pc    <= if_pc;
      p_inst  <= if_inst;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          w;
      logic        ack, stall, redir;
      logic [31:0] tgt;

      // Sequential streaming, one fetch per cycle.
      do_reset(2, 1'b0);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b0, 1'b0, '0);
         chk("seq_addr", ic_addr, 32'(4 * i));
         if (i > 0) begin
            chk1("seq_valid", if_valid, 1'b1);
            chk("seq_pc", if_pc, 32'(4 * (i - 1)));
         end
      end

      // Five-cycle miss at 0x10.
      do_reset(1, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, '0);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, 1'b0, 1'b0, '0);
         chk1("miss_req", ic_req, 1'b1);
         chk("miss_addr", ic_addr, 32'h10);
         if (k > 0) chk1("miss_novalid", if_valid, 1'b0);
      end
      cyc(1'b1, 1'b0, 1'b0, '0);
      chk("miss_ack_addr", ic_addr, 32'h10);
      chk1("miss_ack_novalid", if_valid, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, '0);
      chk1("miss_lat_valid", if_valid, 1'b1);
      chk("miss_lat_pc", if_pc, 32'h10);

      // Decode stall with 0x8 in the slot.
      do_reset(1, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, '0);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 1'b1, 1'b0, '0);
         chk1("hold_valid", if_valid, 1'b1);
         chk("hold_pc", if_pc, 32'h8);
         chk("hold_inst", if_inst, mem(32'h8));
      end
      cyc(1'b1, 1'b0, 1'b0, '0);
      w = 0;
      while (!ic_req && w < 4) begin
         cyc(1'b1, 1'b0, 1'b0, '0);
         w++;
      end
      chk1("resume_req", ic_req, 1'b1);
      chk("resume_addr", ic_addr, 32'hC);

      // Redirect to 0x200 during a miss at 0x40.
      do_reset(1, 1'b0);
      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, '0);
      cyc(1'b0, 1'b0, 1'b1, 32'h200);
      chk("kill_addr", ic_addr, 32'h40);
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, '0);
      cyc(1'b1, 1'b0, 1'b0, '0);
      chk("kill_ack_addr", ic_addr, 32'h40);
      cyc(1'b1, 1'b0, 1'b0, '0);
      chk("redir_addr", ic_addr, 32'h200);

      // Two redirects in one miss, then a redirect coincident with an ack.
      cyc(1'b0, 1'b0, 1'b1, 32'h100);
      chk("kill2_addr", ic_addr, 32'h204);
      cyc(1'b0, 1'b0, 1'b0, '0);
      cyc(1'b0, 1'b0, 1'b1, 32'h302);
      cyc(1'b1, 1'b0, 1'b0, '0);
      chk("kill2_ack_addr", ic_addr, 32'h204);
      cyc(1'b1, 1'b0, 1'b0, '0);
      chk("newest_wins", ic_addr, 32'h300);
      cyc(1'b1, 1'b0, 1'b0, '0);
      cyc(1'b1, 1'b0, 1'b1, 32'h600);
      chk("coinc_addr", ic_addr, 32'h308);
      cyc(1'b1, 1'b0, 1'b0, '0);
      chk("coinc_redir_addr", ic_addr, 32'h600);

      // PC wrap, then reset in the middle of a miss with a late ack in boot.
      cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      cyc(1'b1, 1'b0, 1'b0, '0);
      chk("wrap_top", ic_addr, 32'hFFFF_FFFC);
      cyc(1'b0, 1'b0, 1'b0, '0);
      chk("wrap_zero", ic_addr, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, '0);
      do_reset(1, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, '0);
      chk("refetch_addr", ic_addr, RST_PC);
      cyc(1'b1, 1'b0, 1'b0, '0);
      chk1("refetch_valid", if_valid, 1'b1);
      chk("refetch_pc", if_pc, RST_PC);

      // Random traffic.
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset(int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)));
         end else begin
            ack   = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 3) == 0);
            redir = ($urandom_range(0, 15) == 0);
            tgt   = $urandom;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            cyc(ack, stall, redir, tgt);
         end
      end
      cyc(1'b0, 1'b0, 1'b0, '0);

`ifdef FETCH_PERF_CNT_EN
      chk("perf_stall", perf_stall_cyc, m_stall);
      chk("perf_flush", perf_flush_cnt, m_flush);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
